// File: rtl/int_arith_pkg.sv
// Shared arithmetic helpers for the integer multiplier/divider utility path:
// FSM state type, product width helper and two's-complement magnitude.
package int_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } int_mul_fsm_t;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    // Magnitude of a w-bit two's-complement value held in the low bits of x.
    // The most negative value maps to 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [63:0] twos_mag(input logic [63:0] x, input int w);
        logic [63:0] mask;
        mask = {64{1'b1}} >> (64 - w);
        if (x[w-1]) begin
            return (~x + 64'd1) & mask;
        end
        return x & mask;
    endfunction

endpackage

// File: rtl/int_multiplier_if.sv
// Operand/result handshake bundle for int_multiplier.
// The sgn signal exists only when INT_MULTIPLIER_SIGNED_EN is defined.
interface int_multiplier_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               in_val;
    logic               in_rdy;
    logic [2*WIDTH-1:0] prod;
    logic               out_val;
    logic               out_rdy;
`ifdef INT_MULTIPLIER_SIGNED_EN
    logic               sgn;

    modport master (
        output a, b, sgn, in_val, out_rdy,
        input  in_rdy, prod, out_val
    );

    modport slave (
        input  a, b, sgn, in_val, out_rdy,
        output in_rdy, prod, out_val
    );
`else
    modport master (
        output a, b, in_val, out_rdy,
        input  in_rdy, prod, out_val
    );

    modport slave (
        input  a, b, in_val, out_rdy,
        output in_rdy, prod, out_val
    );
`endif
endinterface

// File: rtl/int_multiplier.sv
// Sequential shift-and-add multiplier, one WIDTH x WIDTH product per WIDTH+2 cycles.
// Define INT_MULTIPLIER_SIGNED_EN to add the sgn input for two's-complement operands.
module int_multiplier
    import int_arith_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic            clk,
    input  logic            rst,
    int_multiplier_if.slave bus
);

    localparam int PW    = prod_width(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    int_mul_fsm_t     state_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    prod_q;
    logic             out_val_q;

    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    prod_d;
    logic [WIDTH-1:0] a_ld;
    logic [WIDTH-1:0] b_ld;

`ifdef INT_MULTIPLIER_SIGNED_EN
    logic neg_q;
    logic neg_d;

    always_comb begin
        a_ld   = bus.a;
        b_ld   = bus.b;
        neg_d  = 1'b0;
        if (bus.sgn) begin
            a_ld  = WIDTH'(twos_mag(64'(bus.a), WIDTH));
            b_ld  = WIDTH'(twos_mag(64'(bus.b), WIDTH));
            neg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end
`else
    assign a_ld = bus.a;
    assign b_ld = bus.b;
`endif

    // Single adder: the only arithmetic on the accumulator path.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
`ifdef INT_MULTIPLIER_SIGNED_EN
        prod_d = neg_q ? (~acc_d + PW'(1)) : acc_d;
`else
        prod_d = acc_d;
`endif
    end

    assign bus.in_rdy  = (state_q == IDLE) && !rst;
    assign bus.prod    = prod_q;
    assign bus.out_val = out_val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            out_val_q <= 1'b0;
`ifdef INT_MULTIPLIER_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_val) begin
                        mcand_q  <= PW'(a_ld);
                        mplier_q <= b_ld;
                        acc_q    <= '0;
                        cnt_q    <= '0;
`ifdef INT_MULTIPLIER_SIGNED_EN
                        neg_q    <= neg_d;
`endif
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // Final step writes the (possibly negated) sum straight to the output.
                    if (cnt_q == LAST_STEP) begin
                        prod_q    <= prod_d;
                        out_val_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_val_q && bus.out_rdy) begin
                        out_val_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_multiplier.sv
// Directed and randomized checks of int_multiplier at WIDTH=12.
// Signed cases run when INT_MULTIPLIER_SIGNED_EN is defined.
module tb_int_multiplier;

    localparam int W = 12;
`ifdef INT_MULTIPLIER_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    int_multiplier_if #(.WIDTH(W)) bus ();

    int_multiplier #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ref_prod(input logic [11:0] a, input logic [11:0] b, input bit s);
        longint p;
        if (s && SIGNED_BUILD) begin
            p = longint'($signed(a)) * longint'($signed(b));
        end else begin
            p = longint'({52'b0, a}) * longint'({52'b0, b});
        end
        return p[23:0];
    endfunction

    // Presents operands and returns one cycle after the accepting edge.
    task automatic issue(input logic [11:0] a, input logic [11:0] b);
        int guard;
        guard = 0;
        bus.a = a;
        bus.b = b;
        bus.in_val = 1'b1;
        while (!bus.in_rdy && guard < 100) begin
            step();
            guard++;
        end
        step();
        bus.in_val = 1'b0;
        tests_run++;
        if (guard >= 100) begin
            fails++;
            $display("FAIL issue_timeout in_rdy=%0b required 1", bus.in_rdy);
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_val && cyc < 60) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (bus.in_rdy !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_rdy got=%0b required 0", bus.in_rdy);
        end
        tests_run++;
        if (bus.out_val !== 1'b0 || bus.prod !== 24'h0) begin
            fails++;
            $display("FAIL reset_outputs out_val=%0b prod=%h required 0/000000", bus.out_val, bus.prod);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.in_rdy !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_in_rdy got=%0b required 1", bus.in_rdy);
        end
    endtask

    task automatic test_max();
        int cyc;
        bus.out_rdy = 1'b1;
        issue(12'd4095, 12'd4095);
        tests_run++;
        if (bus.in_rdy !== 1'b0) begin
            fails++;
            $display("FAIL max_busy_in_rdy got=%0b required 0", bus.in_rdy);
        end
        wait_out(cyc);
        tests_run++;
        if (cyc !== 12) begin
            fails++;
            $display("FAIL max_latency got=%0d required 12", cyc);
        end
        tests_run++;
        if (bus.prod !== 24'hFFE001) begin
            fails++;
            $display("FAIL max_prod got=%h required ffe001", bus.prod);
        end
        step();
        tests_run++;
        if (bus.out_val !== 1'b0 || bus.in_rdy !== 1'b1) begin
            fails++;
            $display("FAIL max_release out_val=%0b in_rdy=%0b required 0/1", bus.out_val, bus.in_rdy);
        end
    endtask

    task automatic test_zero_one();
        int cyc;
        bus.out_rdy = 1'b1;
        issue(12'd0, 12'd1234);
        wait_out(cyc);
        tests_run++;
        if (cyc !== 12 || bus.prod !== 24'h0) begin
            fails++;
            $display("FAIL zero_prod cyc=%0d prod=%h required 12/000000", cyc, bus.prod);
        end
        step();
        issue(12'd1, 12'd1);
        wait_out(cyc);
        tests_run++;
        if (cyc !== 12 || bus.prod !== 24'h1) begin
            fails++;
            $display("FAIL one_prod cyc=%0d prod=%h required 12/000001", cyc, bus.prod);
        end
        step();
    endtask

    task automatic test_backpressure();
        int cyc;
        bus.out_rdy = 1'b0;
        issue(12'd100, 12'd37);
        wait_out(cyc);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bus.out_val !== 1'b1 || bus.prod !== 24'd3700) begin
                fails++;
                $display("FAIL bp_hold cycle=%0d out_val=%0b prod=%0d required 1/3700", i, bus.out_val, bus.prod);
            end
            bus.a = 12'd5;
            bus.b = 12'd5;
            bus.in_val = 1'b1;
            tests_run++;
            if (bus.in_rdy !== 1'b0) begin
                fails++;
                $display("FAIL bp_in_rdy cycle=%0d got=%0b required 0", i, bus.in_rdy);
            end
            step();
        end
        bus.in_val = 1'b0;
        bus.out_rdy = 1'b1;
        step();
        tests_run++;
        if (bus.out_val !== 1'b0 || bus.prod !== 24'd3700 || bus.in_rdy !== 1'b1) begin
            fails++;
            $display("FAIL bp_release out_val=%0b prod=%0d in_rdy=%0b required 0/3700/1", bus.out_val, bus.prod, bus.in_rdy);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        bus.out_rdy = 1'b1;
        issue(12'd7, 12'd9);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            if (bus.out_val) seen = 1'b1;
            step();
        end
        tests_run++;
        if (seen !== 1'b0 || bus.prod !== 24'h0) begin
            fails++;
            $display("FAIL rst_mid_discard seen_out_val=%0b prod=%h required 0/000000", seen, bus.prod);
        end
        issue(12'd3, 12'd4);
        wait_out(cyc);
        tests_run++;
        if (cyc !== 12 || bus.prod !== 24'd12) begin
            fails++;
            $display("FAIL rst_mid_next cyc=%0d prod=%0d required 12/12", cyc, bus.prod);
        end
        step();
    endtask

    task automatic test_signed();
        int cyc;
        bus.out_rdy = 1'b1;
`ifdef INT_MULTIPLIER_SIGNED_EN
        bus.sgn = 1'b1;
        issue(12'hFFD, 12'd5);
        wait_out(cyc);
        tests_run++;
        if (cyc !== 12 || bus.prod !== 24'hFFFFF1) begin
            fails++;
            $display("FAIL signed_neg cyc=%0d prod=%h required 12/fffff1", cyc, bus.prod);
        end
        step();
        issue(12'h800, 12'h800);
        wait_out(cyc);
        tests_run++;
        if (cyc !== 12 || bus.prod !== 24'h400000) begin
            fails++;
            $display("FAIL signed_min cyc=%0d prod=%h required 12/400000", cyc, bus.prod);
        end
        step();
        bus.sgn = 1'b0;
`endif
        issue(12'hFFD, 12'd5);
        wait_out(cyc);
        tests_run++;
        if (cyc !== 12 || bus.prod !== 24'h004FF1) begin
            fails++;
            $display("FAIL unsigned_ffd cyc=%0d prod=%h required 12/004ff1", cyc, bus.prod);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int n;
        bit saw;
        logic [23:0] got1;
        bus.out_rdy = 1'b1;
        bus.a = 12'd25;
        bus.b = 12'd40;
        bus.in_val = 1'b1;
        step();
        bus.a = 12'd123;
        bus.b = 12'd45;
        n = 0;
        saw = 1'b0;
        got1 = '0;
        while (!bus.in_rdy && n < 40) begin
            if (bus.out_val) begin
                saw = 1'b1;
                got1 = bus.prod;
            end
            step();
            n++;
        end
        tests_run++;
        if (saw !== 1'b1 || got1 !== 24'd1000) begin
            fails++;
            $display("FAIL b2b_first saw=%0b prod=%0d required 1/1000", saw, got1);
        end
        tests_run++;
        if (n + 1 !== 14) begin
            fails++;
            $display("FAIL b2b_interval got=%0d required 14", n + 1);
        end
        step();
        bus.in_val = 1'b0;
        wait_out(cyc);
        tests_run++;
        if (cyc !== 12 || bus.prod !== 24'd5535) begin
            fails++;
            $display("FAIL b2b_second cyc=%0d prod=%0d required 12/5535", cyc, bus.prod);
        end
        step();
    endtask

    task automatic test_random();
        int in_hs;
        int out_hs;
        bit done;
        bit hs;
        bit s;
        logic [11:0] a;
        logic [11:0] b;
        logic [23:0] exp;
        in_hs = 0;
        out_hs = 0;
        for (int k = 0; k < 1000; k++) begin
            a = 12'($urandom_range(0, 4095));
            b = 12'($urandom_range(0, 4095));
            s = 1'($urandom_range(0, 1));
`ifdef INT_MULTIPLIER_SIGNED_EN
            bus.sgn = s;
`else
            s = 1'b0;
`endif
            exp = ref_prod(a, b, s);
            bus.out_rdy = 1'($urandom_range(0, 1));
            issue(a, b);
            in_hs++;
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                bus.out_rdy = 1'($urandom_range(0, 1));
                hs = bus.out_val && bus.out_rdy;
                if (hs) begin
                    tests_run++;
                    if (bus.prod !== exp) begin
                        fails++;
                        $display("FAIL rand_prod a=%h b=%h s=%0b got=%h required %h", a, b, s, bus.prod, exp);
                    end
                    out_hs++;
                    done = 1'b1;
                end
                step();
            end
            tests_run++;
            if (!done || bus.out_val !== 1'b0) begin
                fails++;
                $display("FAIL rand_handshake a=%h b=%h done=%0b out_val=%0b required 1/0", a, b, done, bus.out_val);
            end
        end
        tests_run++;
        if (out_hs !== in_hs) begin
            fails++;
            $display("FAIL rand_count out=%0d required %0d", out_hs, in_hs);
        end
        bus.out_rdy = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.a = '0;
        bus.b = '0;
        bus.in_val = 1'b0;
        bus.out_rdy = 1'b0;
`ifdef INT_MULTIPLIER_SIGNED_EN
        bus.sgn = 1'b0;
`endif
        test_reset();
        test_max();
        test_zero_one();
        test_backpressure();
        test_reset_mid();
        test_signed();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
